// File: rtl/pipe_decoder_pkg.sv
// Shared types, constants and helpers for the registered select decoder.
// Helpers work on the widest legal index so every instance can share them.
package pipe_decoder_pkg;

    localparam logic MODE_ONEHOT = 1'b0;
    localparam logic MODE_THERMO = 1'b1;

    localparam int MAX_SEL_W = 8;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    // Reverse the low w bits of v; bits at and above w come back zero.
    function automatic logic [MAX_SEL_W-1:0] bit_rev(
        input logic [MAX_SEL_W-1:0] v,
        input int                   w
    );
        logic [MAX_SEL_W-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_SEL_W; i++) begin
            if (i < w) begin
                r[3'(w - 1 - i)] = v[i];
            end
        end
        return r;
    endfunction

    function automatic logic dec_bit(
        input int                   k,
        input logic [MAX_SEL_W-1:0] idx,
        input logic                 mode
    );
        int i;
        i = int'(idx);
        if (mode == MODE_THERMO) begin
            return k <= i;
        end
        return k == i;
    endfunction

endpackage

// File: rtl/pipe_decoder_if.sv
// Valid/ready select-in, decoded-out bundle plus error counter controls.
// master drives selects and ready; slave is the decoder.
interface pipe_decoder_if #(
    parameter int SEL_W     = 3,
    parameter int N_OUT     = 8,
    parameter int ERR_CNT_W = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [SEL_W-1:0]     in_sel;
    logic                 in_mode;
    logic                 out_valid;
    logic                 out_ready;
    logic [N_OUT-1:0]     out_dec;
    logic                 out_err;
    logic                 err_clr;
    logic [ERR_CNT_W-1:0] err_cnt;

    modport master (
        output in_valid,
        output in_sel,
        output in_mode,
        output out_ready,
        output err_clr,
        input  in_ready,
        input  out_valid,
        input  out_dec,
        input  out_err,
        input  err_cnt
    );

    modport slave (
        input  in_valid,
        input  in_sel,
        input  in_mode,
        input  out_ready,
        input  err_clr,
        output in_ready,
        output out_valid,
        output out_dec,
        output out_err,
        output err_cnt
    );
endinterface

// File: rtl/pipe_decoder_dec_core.sv
// Combinational index to one-hot / thermometer decode with range flag.
// Usable unregistered wherever a plain decode is enough.
module dec_core
    import pipe_decoder_pkg::*;
#(
    parameter int N_OUT = 8
) (
    input  logic [MAX_SEL_W-1:0] idx_i,
    input  logic                 mode_i,
    output logic [N_OUT-1:0]     dec_o,
    output logic                 err_o
);

    always_comb begin
        err_o = int'(idx_i) >= N_OUT;
        dec_o = '0;
        for (int k = 0; k < N_OUT; k++) begin
            dec_o[k] = !err_o && dec_bit(k, idx_i, mode_i);
        end
    end

endmodule

// File: rtl/pipe_decoder.sv
// Registered, flow-controlled select decoder with saturating
// out-of-range counter.
module pipe_decoder
    import pipe_decoder_pkg::*;
#(
    parameter int SEL_W     = 3,
    parameter int N_OUT     = 8,
    parameter int BIT_REV   = 1,
    parameter int ERR_CNT_W = 8
) (
    input logic           clk,
    input logic           rst_n,
    pipe_decoder_if.slave bus
);

    state_e               state_q, state_d;
    logic [N_OUT-1:0]     dec_q, dec_d, dec_w;
    logic                 err_q, err_d, err_w;
    logic [ERR_CNT_W-1:0] cnt_q, cnt_d;
    logic [MAX_SEL_W-1:0] sel_w, idx_w;
    logic                 in_ready;
    logic                 accept;

    assign sel_w = MAX_SEL_W'(bus.in_sel);
    assign idx_w = (BIT_REV != 0) ? bit_rev(sel_w, SEL_W) : sel_w;

    dec_core #(
        .N_OUT(N_OUT)
    ) u_core (
        .idx_i  (idx_w),
        .mode_i (bus.in_mode),
        .dec_o  (dec_w),
        .err_o  (err_w)
    );

    // Downstream ready passes straight through so a full stage still streams.
    assign in_ready = (state_q == EMPTY) || bus.out_ready;
    assign accept   = bus.in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        dec_d   = dec_q;
        err_d   = err_q;
        unique case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d = FULL;
                end
            end
            FULL: begin
                if (bus.out_ready && !accept) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (accept) begin
            dec_d = dec_w;
            err_d = err_w;
        end
    end

    // Clear first, then count, so clear plus a bad word leaves one.
    always_comb begin
        cnt_d = bus.err_clr ? '0 : cnt_q;
        if (accept && err_w && (cnt_d != '1)) begin
            cnt_d = cnt_d + ERR_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            dec_q   <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            dec_q   <= dec_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_q == FULL);
    assign bus.out_dec   = dec_q;
    assign bus.out_err   = err_q;
    assign bus.err_cnt   = cnt_q;

endmodule

// File: tb/tb_pipe_decoder.sv
// Bench for pipe_decoder: two configurations against a behavioural model.
module tb_pipe_decoder;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    pipe_decoder_if #(.SEL_W(3), .N_OUT(8), .ERR_CNT_W(8)) ia ();
    pipe_decoder_if #(.SEL_W(3), .N_OUT(6), .ERR_CNT_W(2)) ib ();

    pipe_decoder #(
        .SEL_W(3), .N_OUT(8), .BIT_REV(1), .ERR_CNT_W(8)
    ) ua (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ia)
    );

    pipe_decoder #(
        .SEL_W(3), .N_OUT(6), .BIT_REV(0), .ERR_CNT_W(2)
    ) ub (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ib)
    );

    int nout_c[2] = '{8, 6};
    int rev_c[2]  = '{1, 0};
    int cmax_c[2] = '{255, 3};

    logic       mv[2] = '{1'b0, 1'b0};
    logic [7:0] md[2] = '{8'h00, 8'h00};
    logic       me[2] = '{1'b0, 1'b0};
    int         mc[2] = '{0, 0};

    task automatic chk(input string n, input logic [31:0] a,
                       input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", n, a, e, $time);
        end
    endtask

    task automatic step(input int i, input logic v, input logic [2:0] sel,
                        input logic mode, input logic ordy, input logic clr);
        int   idx;
        logic acc;
        acc = v && (!mv[i] || ordy);
        idx = 0;
        for (int b = 0; b < 3; b++) begin
            if (sel[b] === 1'b1) idx += 1 << ((rev_c[i] != 0) ? 2 - b : b);
        end
        if (clr) mc[i] = 0;
        if (acc && idx >= nout_c[i] && mc[i] < cmax_c[i]) mc[i]++;
        if (acc) begin
            mv[i] = 1'b1;
            me[i] = idx >= nout_c[i];
            if (me[i]) md[i] = 8'h00;
            else if (mode) md[i] = 8'((2 << idx) - 1);
            else md[i] = 8'(1 << idx);
        end else if (ordy) begin
            mv[i] = 1'b0;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                mv[i] = 1'b0;
                md[i] = 8'h00;
                me[i] = 1'b0;
                mc[i] = 0;
            end
        end else begin
            step(0, ia.in_valid, ia.in_sel, ia.in_mode, ia.out_ready,
                 ia.err_clr);
            step(1, ib.in_valid, ib.in_sel, ib.in_mode, ib.out_ready,
                 ib.err_clr);
        end
    end

    always @(negedge clk) begin
        chk("a_valid", 32'(ia.out_valid), 32'(mv[0]));
        chk("a_in_ready", 32'(ia.in_ready), 32'(!mv[0] || ia.out_ready));
        if (mv[0]) begin
            chk("a_dec", 32'(ia.out_dec), 32'(md[0]));
            chk("a_err", 32'(ia.out_err), 32'(me[0]));
        end
        chk("a_cnt", 32'(ia.err_cnt), 32'(mc[0]));
        chk("b_valid", 32'(ib.out_valid), 32'(mv[1]));
        chk("b_in_ready", 32'(ib.in_ready), 32'(!mv[1] || ib.out_ready));
        if (mv[1]) begin
            chk("b_dec", 32'(ib.out_dec), 32'(md[1]));
            chk("b_err", 32'(ib.out_err), 32'(me[1]));
        end
        chk("b_cnt", 32'(ib.err_cnt), 32'(mc[1]));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        ia.in_valid = 0; ia.in_sel = 0; ia.in_mode = 0;
        ia.out_ready = 1; ia.err_clr = 0;
        ib.in_valid = 0; ib.in_sel = 0; ib.in_mode = 0;
        ib.out_ready = 1; ib.err_clr = 0;

        #1;
        chk("rst_valid", 32'(ia.out_valid), 0);
        chk("rst_in_ready", 32'(ia.in_ready), 1);
        chk("rst_dec", 32'(ia.out_dec), 0);
        chk("rst_cnt", 32'(ia.err_cnt), 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();

        // one-hot, reversed bit order
        ia.in_valid = 1; ia.in_mode = 0; ia.in_sel = 3'b001;
        tick();
        ia.in_valid = 0;
        chk("t1_dec", 32'(ia.out_dec), 32'h10);
        chk("t1_valid", 32'(ia.out_valid), 1);
        chk("t1_err", 32'(ia.out_err), 0);
        tick();

        // thermometer back to back
        ia.in_valid = 1; ia.in_mode = 1; ia.in_sel = 3'b110;
        tick();
        chk("t2_dec0", 32'(ia.out_dec), 32'h0F);
        chk("t2_rdy", 32'(ia.in_ready), 1);
        ia.in_sel = 3'b111;
        tick();
        chk("t2_dec1", 32'(ia.out_dec), 32'hFF);
        ia.in_valid = 0;
        tick();

        // backpressure
        ia.in_valid = 1; ia.in_mode = 0; ia.in_sel = 3'b000;
        tick();
        chk("bp_dec0", 32'(ia.out_dec), 32'h01);
        ia.out_ready = 0; ia.in_sel = 3'b100;
        for (int n = 0; n < 3; n++) begin
            tick();
            chk("bp_rdy", 32'(ia.in_ready), 0);
            chk("bp_hold", 32'(ia.out_dec), 32'h01);
        end
        ia.out_ready = 1;
        tick();
        chk("bp_next", 32'(ia.out_dec), 32'h02);
        ia.in_valid = 0;
        tick();

        // out of range, N_OUT=6 natural order
        ib.in_valid = 1; ib.in_mode = 0; ib.in_sel = 3'b111;
        tick();
        chk("oor_dec", 32'(ib.out_dec), 0);
        chk("oor_err", 32'(ib.out_err), 1);
        chk("oor_cnt", 32'(ib.err_cnt), 1);
        ib.in_sel = 3'b101;
        tick();
        chk("in_dec", 32'(ib.out_dec), 32'h20);
        chk("in_err", 32'(ib.out_err), 0);
        chk("in_cnt", 32'(ib.err_cnt), 1);
        ib.in_valid = 0; ib.err_clr = 1;
        tick();
        ib.err_clr = 0;
        chk("clr_cnt", 32'(ib.err_cnt), 0);

        // saturation and clear-with-count
        ib.in_valid = 1; ib.in_sel = 3'b110;
        repeat (5) tick();
        chk("sat_cnt", 32'(ib.err_cnt), 3);
        ib.err_clr = 1;
        tick();
        chk("clr_inc", 32'(ib.err_cnt), 1);
        ib.err_clr = 0; ib.in_valid = 0;
        tick();

        for (int n = 0; n < 600; n++) begin
            ia.in_valid  = 1'($urandom_range(0, 1));
            ia.in_sel    = 3'($urandom);
            ia.in_mode   = 1'($urandom_range(0, 1));
            ia.out_ready = $urandom_range(0, 3) != 0;
            ia.err_clr   = $urandom_range(0, 19) == 0;
            if (!ia.in_valid && n[0]) ia.in_sel = 'x;
            ib.in_valid  = 1'($urandom_range(0, 1));
            ib.in_sel    = 3'($urandom);
            ib.in_mode   = 1'($urandom_range(0, 1));
            ib.out_ready = $urandom_range(0, 3) != 0;
            ib.err_clr   = $urandom_range(0, 19) == 0;
            tick();
        end
        ia.in_valid = 0; ia.out_ready = 1; ia.err_clr = 0;
        ib.in_valid = 0; ib.out_ready = 1; ib.err_clr = 0;
        repeat (2) tick();

        // async reset while full and stalled
        ia.in_valid = 1; ia.in_mode = 0; ia.in_sel = 3'b000;
        ib.in_valid = 1; ib.in_mode = 0; ib.in_sel = 3'b111;
        tick();
        ia.in_valid = 0; ia.out_ready = 0;
        ib.in_valid = 0; ib.out_ready = 0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid", 32'(ia.out_valid), 0);
        chk("ar_dec", 32'(ia.out_dec), 0);
        chk("ar_err", 32'(ia.out_err), 0);
        chk("ar_cnt", 32'(ia.err_cnt), 0);
        chk("ar_rdy", 32'(ia.in_ready), 1);
        chk("ar_b_valid", 32'(ib.out_valid), 0);
        chk("ar_b_err", 32'(ib.out_err), 0);
        chk("ar_b_cnt", 32'(ib.err_cnt), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        ia.out_ready = 1; ib.out_ready = 1;
        tick();
        chk("ar_noreplay", 32'(ib.out_valid), 0);
        ia.in_valid = 1; ia.in_sel = 3'b010;
        tick();
        chk("ar_after", 32'(ia.out_dec), 32'h04);
        ia.in_valid = 0;
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_decoder.md
Name: pipe_decoder

Overview:
Parametrised, registered binary-to-1-of-N decoder with a valid/ready handshake on both sides. It generalises the fixed 3-to-8 combinational decoder in four ways: select width and output count are parametrised; there is a per-transaction one-hot/thermometer mode; codes outside the output range are flagged; a saturating error counter is provided. It sits between a select-producing control block and downstream enable/mux fabric that needs registered, flow-controlled selects.

Parameters:
SEL_W, 3, select input width in bits; legal range 1..8.
N_OUT, 8, number of decoded outputs; legal range 2..2**SEL_W.
BIT_REV, 1, input bit ordering. 1: in_sel[0] is the most significant select bit (existing 3-to-8 ordering). 0: in_sel[0] is the LSB.
ERR_CNT_W, 8, width of the saturating out-of-range counter.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  select word valid
in_ready  output  1  block can accept a select word this cycle
in_sel  input  SEL_W  binary select code
in_mode  input  1  0 = one-hot, 1 = thermometer; sampled with in_sel
out_valid  output  1  out_dec/out_err valid
out_ready  input  1  downstream accepts the output this cycle
out_dec  output  N_OUT  decoded vector
out_err  output  1  registered word was out of range
err_clr  input  1  synchronous clear of err_cnt
err_cnt  output  ERR_CNT_W  saturating count of accepted out-of-range codes

Behaviour:
- Reset is one clock, asynchronous and active-low: rst_n low clears all state immediately, independent of clk.
- Reset values: out_valid=0, out_dec=0, out_err=0, err_cnt=0. in_ready=1 during and after reset.
- Index: idx = BIT_REV ? bit-reverse(in_sel) : in_sel, taken as unsigned SEL_W bits.
- Range check: out of range when idx >= N_OUT. This is only possible when N_OUT < 2**SEL_W.
- One-hot mode: out_dec[idx]=1; all other bits 0.
- Thermometer mode: out_dec[k]=1 for all k <= idx; all other bits 0.
- Out of range, either mode: out_dec=0 and out_err=1. Otherwise out_err=0.
- Pipeline: a single output register stage.
  - in_ready = !out_valid || out_ready, a combinational pass-through of downstream ready.
  - Accept = in_valid && in_ready. On accept, the register loads the decoded word and out_valid=1 on the next edge. Latency is 1 cycle.
  - out_valid && out_ready && !accept: out_valid drops to 0 on the next edge.
  - Simultaneous consume and accept: the new word replaces the old one, out_valid stays 1, and there is no bubble. Full throughput is 1 word/cycle.
  - Stall (out_valid && !out_ready): out_dec, out_err and out_valid hold stable and in_ready=0.
- in_valid while in_ready=0 is ignored. No upstream state is captured.
- States are implicit: EMPTY (out_valid=0) and FULL (out_valid=1).
  - EMPTY -> FULL on accept.
  - FULL -> EMPTY on consume without accept.
  - FULL -> FULL on consume with accept, or on stall.
- err_cnt:
  - Increments by 1 on each accepted out-of-range word and saturates at all-ones.
  - err_clr=1 sets it to 0.
  - err_clr in the same cycle as an out-of-range accept gives err_cnt=1: clear is applied, then the count.
  - Stalled or rejected words never count.
- rst_n asserted mid-stall: the held word is discarded, out_valid=0 immediately, and nothing is replayed after reset.
- X on in_sel while in_valid=0 must not propagate to state.

Decomposition:
- Shared package pipe_decoder_pkg:
  - mode encoding constants MODE_ONEHOT=1'b0 and MODE_THERMO=1'b1;
  - a function for the bit-reverse index;
  - a function for the one-hot and thermometer vector generation.
- One natural sub-module: dec_core, purely combinational. It takes idx and mode and returns dec and err, and can be reused unregistered elsewhere. The top level holds the handshake register and the error counter.

Test Plan:
- Defaults, in_mode=0, in_sel=3'b001, out_ready=1 -> next cycle out_valid=1, out_dec=8'h10 (idx 4), out_err=0.
- Defaults, in_mode=1, in_sel=3'b110 (idx 3) -> out_dec=8'h0F. Then in_sel=3'b111 -> 8'hFF, on back-to-back cycles with in_ready held 1.
- N_OUT=6, BIT_REV=0, in_sel=3'b111, one-hot -> out_dec=6'h00, out_err=1, err_cnt=1. Then in_sel=3'b101 -> out_dec=6'h20, out_err=0, err_cnt still 1.
- Backpressure: accept in_sel=3'b000 (out_dec=8'h01), hold out_ready=0 for 3 cycles with in_valid=1 and in_sel=3'b100:
  - during the stall: in_ready=0, out_dec stays 8'h01;
  - on release: the next word 8'h02 appears one cycle later.
- ERR_CNT_W=2, N_OUT=6:
  - 5 accepted out-of-range codes -> err_cnt=3 (saturated);
  - then err_clr=1 together with one out-of-range accept -> err_cnt=1.
- Assert rst_n=0 asynchronously (between edges) while FULL and stalled -> out_valid, out_dec, out_err and err_cnt are 0 immediately and in_ready=1. Release, then in_sel=3'b010 -> out_dec=8'h04.
